// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: datapath width, bubble encoding, fetch FSM
// states and the IF/ID bundle reused by later pipeline registers.
package riscv_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0100_0000;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] inst;
    } ifid_t;

    // Bubble value: no real instruction, decode sees addi x0,x0,0.
    function automatic ifid_t ifid_bubble(input logic [XLEN-1:0] nop_word);
        ifid_t b;
        b.valid    = 1'b0;
        b.pc       = {XLEN{1'b0}};
        b.pc_plus4 = {XLEN{1'b0}};
        b.inst     = nop_word;
        return b;
    endfunction

endpackage

// File: rtl/pipe_reg_ifid.sv
// IF/ID pipeline register with load / hold / flush controls.
// Flush turns the slot into a bubble but keeps the last pc fields.
module pipe_reg_ifid
    import riscv_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_INST
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  load_s,
    input  logic  flush_s,
    input  ifid_t d_s,
    output ifid_t q_r
);

    // Register update: flush has priority over load, otherwise hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_r <= ifid_bubble(NOP_WORD);
        end else if (flush_s) begin
            q_r.valid <= 1'b0;
            q_r.inst  <= NOP_WORD;
        end else if (load_s) begin
            q_r <= d_s;
        end else begin
            q_r <= q_r;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC selection, run/halt FSM, fetch counter
// and the IF/ID register feeding decode.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = riscv_pkg::NOP_INST
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_inst,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    fetch_state_e state_r;
    fetch_state_e next_state_s;
    logic [31:0]  pc_r;
    logic [31:0]  pc_next_s;
    logic [31:0]  pc_plus4_s;
    logic [31:0]  fetch_count_r;
    logic [31:0]  count_next_s;
    logic         fetch_fault_r;
    logic         fault_next_s;
    logic         load_s;
    logic         flush_s;
    ifid_t        ifid_d_s;
    ifid_t        ifid_q_r;

    assign pc_plus4_s = pc_r + 32'd4;

    // Next-state, next-PC and IF/ID control; redirect outranks stall.
    always_comb begin
        next_state_s = state_r;
        pc_next_s    = pc_r;
        count_next_s = fetch_count_r;
        fault_next_s = fetch_fault_r;
        load_s       = 1'b0;
        flush_s      = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                    next_state_s = ST_HALT;
                    fault_next_s = 1'b1;
                    flush_s      = 1'b1;
                end else if (redirect_valid) begin
                    pc_next_s = redirect_pc;
                    flush_s   = 1'b1;
                end else if (stall) begin
                    pc_next_s = pc_r;
                end else begin
                    pc_next_s    = pc_plus4_s;
                    load_s       = 1'b1;
                    count_next_s = fetch_count_r + 32'd1;
                end
            end
            ST_HALT: begin
                next_state_s = ST_HALT;
            end
            default: begin
                // Corrupted state encoding: freeze and flag rather than fetch.
                next_state_s = ST_HALT;
                fault_next_s = 1'b1;
                flush_s      = 1'b1;
            end
        endcase
    end

    // Bundle presented to IF/ID on a normal fetch.
    always_comb begin
        ifid_d_s.valid    = 1'b1;
        ifid_d_s.pc       = pc_r;
        ifid_d_s.pc_plus4 = pc_plus4_s;
        ifid_d_s.inst     = imem_data;
    end

    // PC, FSM, fault flag and counter state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= ST_RUN;
            pc_r          <= RESET_PC;
            fetch_count_r <= 32'd0;
            fetch_fault_r <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            pc_r          <= pc_next_s;
            fetch_count_r <= count_next_s;
            fetch_fault_r <= fault_next_s;
        end
    end

    pipe_reg_ifid #(
        .NOP_WORD (NOP_INST)
    ) u_ifid (
        .clock   (clock),
        .reset   (reset),
        .load_s  (load_s),
        .flush_s (flush_s),
        .d_s     (ifid_d_s),
        .q_r     (ifid_q_r)
    );

    assign imem_addr   = pc_r;
    assign id_valid    = ifid_q_r.valid;
    assign id_pc       = ifid_q_r.pc;
    assign id_pc_plus4 = ifid_q_r.pc_plus4;
    assign id_inst     = ifid_q_r.inst;
    assign fetch_fault = fetch_fault_r;
    assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: hand-computed expectations per step,
// with a small combinational instruction memory.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_inst;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    int vectors;
    int miscompares;

    fetch_stage dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_inst        (id_inst),
        .fetch_fault    (fetch_fault),
        .fetch_count    (fetch_count)
    );

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        case (a)
            32'h0100_0000: return 32'h0050_0093;
            32'h0100_0004: return 32'h0010_0113;
            default:       return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    assign imem_data = imem_word(imem_addr);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_id(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] pc4, input logic [31:0] inst);
        check({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, v});
        check({tag, ".id_pc"}, id_pc, pc);
        check({tag, ".id_pc_plus4"}, id_pc_plus4, pc4);
        check({tag, ".id_inst"}, id_inst, inst);
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        // Reset state
        step();
        step();
        check_id("rst", 1'b0, 32'd0, 32'd0, NOP);
        check("rst.imem_addr", imem_addr, 32'h0100_0000);
        check("rst.fault", {31'd0, fetch_fault}, 32'd0);
        check("rst.count", fetch_count, 32'd0);
        reset = 1'b0;

        // 1: straight-line fetch
        step();
        check_id("t1e1", 1'b1, 32'h0100_0000, 32'h0100_0004, 32'h0050_0093);
        check("t1e1.count", fetch_count, 32'd1);
        step();
        check_id("t1e2", 1'b1, 32'h0100_0004, 32'h0100_0008, 32'h0010_0113);
        check("t1e2.count", fetch_count, 32'd2);
        check("t1e2.imem_addr", imem_addr, 32'h0100_0008);

        // 2: three stalled edges then resume
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2.stall.imem_addr", imem_addr, 32'h0100_0008);
            check_id("t2.stall", 1'b1, 32'h0100_0004, 32'h0100_0008, 32'h0010_0113);
            check("t2.stall.count", fetch_count, 32'd2);
        end
        stall = 1'b0;
        step();
        check_id("t2.resume", 1'b1, 32'h0100_0008, 32'h0100_000C, 32'hA4A5_0008);
        check("t2.resume.count", fetch_count, 32'd3);
        check("t2.resume.imem_addr", imem_addr, 32'h0100_000C);

        // 3: redirect with simultaneous stall
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0100;
        stall          = 1'b1;
        step();
        check("t3.imem_addr", imem_addr, 32'h0100_0100);
        check_id("t3.flush", 1'b0, 32'h0100_0008, 32'h0100_000C, NOP);
        check("t3.count", fetch_count, 32'd3);
        redirect_valid = 1'b0;
        stall          = 1'b0;
        step();
        check_id("t3.next", 1'b1, 32'h0100_0100, 32'h0100_0104, 32'hA4A5_0100);
        check("t3.next.count", fetch_count, 32'd4);

        // 5: PC wrap at top of address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        check("t5.redir.imem_addr", imem_addr, 32'hFFFF_FFFC);
        check("t5.redir.count", fetch_count, 32'd4);
        redirect_valid = 1'b0;
        step();
        check("t5.wrap.imem_addr", imem_addr, 32'h0000_0000);
        check_id("t5.wrap", 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 32'h5A5A_FFFC);
        check("t5.wrap.fault", {31'd0, fetch_fault}, 32'd0);
        check("t5.wrap.count", fetch_count, 32'd5);

        // 6: asynchronous reset between edges
        #2;
        reset = 1'b1;
        #1;
        check_id("t6.async", 1'b0, 32'd0, 32'd0, NOP);
        check("t6.async.imem_addr", imem_addr, 32'h0100_0000);
        check("t6.async.count", fetch_count, 32'd0);
        reset = 1'b0;
        step();
        check_id("t6.post", 1'b1, 32'h0100_0000, 32'h0100_0004, 32'h0050_0093);
        check("t6.post.count", fetch_count, 32'd1);
        step();
        check("t6.post2.imem_addr", imem_addr, 32'h0100_0008);

        // 4: misaligned redirect -> sticky halt
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0102;
        step();
        check("t4.fault", {31'd0, fetch_fault}, 32'd1);
        check("t4.imem_addr", imem_addr, 32'h0100_0008);
        check_id("t4.flush", 1'b0, 32'h0100_0004, 32'h0100_0008, NOP);
        check("t4.count", fetch_count, 32'd2);
        redirect_pc = 32'h0100_0200;
        step();
        check("t4.redir_ignored.imem_addr", imem_addr, 32'h0100_0008);
        check("t4.redir_ignored.fault", {31'd0, fetch_fault}, 32'd1);
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("t4.halt.imem_addr", imem_addr, 32'h0100_0008);
            check_id("t4.halt", 1'b0, 32'h0100_0004, 32'h0100_0008, NOP);
            check("t4.halt.count", fetch_count, 32'd2);
            check("t4.halt.fault", {31'd0, fetch_fault}, 32'd1);
        end
        reset = 1'b1;
        #1;
        check("t4.reset.fault", {31'd0, fetch_fault}, 32'd0);
        reset = 1'b0;
        step();
        check("t4.reset.run.count", fetch_count, 32'd1);
        check("t4.reset.run.imem_addr", imem_addr, 32'h0100_0004);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
